// File: rtl/muldiv_pkg.sv
// Shared constants for the multiply/divide unit: funct codes (also used by
// the control unit decoder), FSM state encoding and the divide-by-zero fill.
package muldiv_pkg;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  // Quotient forced on divide by zero; sliced to the unit width by the user.
  localparam logic [63:0] DIVZERO_LO = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

  function automatic logic funct_valid(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative datapath.
// Multiply: shift-add, LSB of the low word selects whether op_i is added.
// Divide: restoring shift-subtract; remainder in the high word, dividend
// bits shift out of the low word MSB-first. The quotient bit is returned
// separately and inserted into bit 0 by the parent.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   op_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               q_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_new;
  logic             ge;

  // Single-iteration combinational step for both modes.
  always_comb begin
    sum     = '0;
    rem_sh  = '0;
    rem_new = '0;
    ge      = 1'b0;
    acc_o   = acc_i;
    q_o     = 1'b0;
    if (!div_i) begin
      sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, op_i} : '0);
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end else begin
      rem_sh  = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
      ge      = (rem_sh >= {1'b0, op_i});
      rem_new = ge ? WIDTH'(rem_sh - {1'b0, op_i}) : rem_sh[WIDTH-1:0];
      acc_o   = {rem_new, acc_i[WIDTH-2:0], 1'b0};
      q_o     = ge;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit. Operands are converted to magnitudes
// on acceptance, WIDTH unsigned iterations run, and signs are restored in
// FIX before Hi/Lo are written.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Start,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH);

  md_state_t          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;     // result (product/quotient) negated
  logic               rneg_q, rneg_d;   // remainder negated (dividend sign)
  logic               dzp_q, dzp_d;     // current divide has a zero divisor
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dz_q, dz_d;

  logic [2*WIDTH-1:0] step_acc;
  logic               step_q;

  logic               f_sgn, f_div, a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b, quo, rem;
  logic [2*WIDTH-1:0] prod;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i (div_q),
    .acc_i (acc_q),
    .op_i  (opb_q),
    .acc_o (step_acc),
    .q_o   (step_q)
  );

  // Next-state, datapath updates and result correction.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    opa_d   = opa_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dzp_d   = dzp_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    prod    = '0;
    quo     = '0;
    rem     = '0;
    f_sgn   = (Funct == FN_MULT) || (Funct == FN_DIV);
    f_div   = (Funct == FN_DIV) || (Funct == FN_DIVU);
    a_neg   = f_sgn & A[WIDTH-1];
    b_neg   = f_sgn & B[WIDTH-1];
    abs_a   = a_neg ? -A : A;
    abs_b   = b_neg ? -B : B;
    unique case (state_q)
      ST_IDLE: begin
        if (Start && funct_valid(Funct)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          div_d   = f_div;
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          dzp_d   = f_div && (B == '0);
          dz_d    = 1'b0;
          opa_d   = A;
          if (f_div) begin
            acc_d = {{WIDTH{1'b0}}, abs_a};
            opb_d = abs_b;
          end else begin
            acc_d = {{WIDTH{1'b0}}, abs_b};
            opb_d = abs_a;
          end
        end
      end
      ST_RUN: begin
        acc_d = div_q ? {step_acc[2*WIDTH-1:1], step_q} : step_acc;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (!div_q) begin
          prod = neg_q ? -acc_q : acc_q;
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (dzp_q) begin
          hi_d = opa_q;
          lo_d = DIVZERO_LO[WIDTH-1:0];
          dz_d = 1'b1;
        end else begin
          quo  = acc_q[WIDTH-1:0];
          rem  = acc_q[2*WIDTH-1:WIDTH];
          lo_d = neg_q ? -quo : quo;
          hi_d = rneg_q ? -rem : rem;
        end
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; Clr aborts any operation at once.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      opa_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dzp_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      opa_q   <= opa_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dzp_q   <= dzp_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  assign Busy    = (state_q != ST_IDLE);
  assign Done    = (state_q == ST_DONE);
  assign Hi      = hi_q;
  assign Lo      = lo_q;
  assign DivZero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table through a scoreboard
// queue, plus hand-written sequences for ignored starts, invalid funct and
// mid-operation clear.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Clr = 1'b1;
  logic         Start = 1'b0;
  logic [5:0]   Funct = '0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Busy, Done, DivZero;
  logic [W-1:0] Hi, Lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Clr(Clr), .Start(Start), .Funct(Funct), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo), .DivZero(DivZero)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t        tbl[$];
  vec_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] f, input logic [31:0] a, b, hi, lo,
                              input logic dz);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.dz = dz;
    return v;
  endfunction

  // Issue one operation, track latency/Busy, and compare against the
  // scoreboard entry when Done appears.
  task automatic run_op(input vec_t v, input bit interfere);
    int   n;
    int   busy_cnt;
    bit   got;
    vec_t e;
    @(negedge Clk);
    Start = 1'b1; Funct = v.f; A = v.a; B = v.b;
    sb.push_back(v);
    @(negedge Clk);
    Start = 1'b0; Funct = FN_MULT; A = $urandom; B = $urandom;
    chk("accept_busy", {63'd0, Busy}, 64'd1);
    chk("accept_dz_clear", {63'd0, DivZero}, 64'd0);
    n = 1; busy_cnt = 0; got = 0;
    while (n <= 100) begin
      if (Busy) busy_cnt++;
      if (Done) begin got = 1; break; end
      if (n == 20) begin
        chk("hold_hi", {32'd0, Hi}, {32'd0, prev_hi});
        chk("hold_lo", {32'd0, Lo}, {32'd0, prev_lo});
      end
      if (interfere && n == 5) begin
        Start = 1'b1; Funct = FN_DIVU; A = 32'd1000; B = 32'd9;
      end
      if (interfere && n == 6) Start = 1'b0;
      @(negedge Clk);
      n++;
    end
    if (!got) begin
      chk("done_timeout", 64'd0, 64'd1);
      return;
    end
    chk("latency", 64'(n), 64'd34);
    chk("busy_cycles", 64'(busy_cnt), 64'd34);
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    chk("hi", {32'd0, Hi}, {32'd0, e.hi});
    chk("lo", {32'd0, Lo}, {32'd0, e.lo});
    chk("divzero", {63'd0, DivZero}, {63'd0, e.dz});
    @(negedge Clk);
    chk("done_one_cycle", {63'd0, Done}, 64'd0);
    chk("busy_after", {63'd0, Busy}, 64'd0);
    chk("hi_held", {32'd0, Hi}, {32'd0, e.hi});
    prev_hi = e.hi;
    prev_lo = e.lo;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back(mk(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0));
    tbl.push_back(mk(FN_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0));
    tbl.push_back(mk(FN_MULT,  32'd0,         32'h1234_5678, 32'h0,         32'h0,         1'b0));
    tbl.push_back(mk(FN_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0));
    tbl.push_back(mk(FN_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0));
    tbl.push_back(mk(FN_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         1'b0));
    tbl.push_back(mk(FN_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0));
    tbl.push_back(mk(FN_DIV,   32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0));
    tbl.push_back(mk(FN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0));
    tbl.push_back(mk(FN_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1));
    tbl.push_back(mk(FN_MULTU, 32'd3,         32'd4,         32'd0,         32'd12,        1'b0));
    tbl.push_back(mk(FN_DIV,   32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1));

    // Reset state
    #12;
    chk("rst_busy", {63'd0, Busy}, 64'd0);
    chk("rst_done", {63'd0, Done}, 64'd0);
    chk("rst_dz", {63'd0, DivZero}, 64'd0);
    chk("rst_hilo", {Hi, Lo}, 64'd0);
    @(negedge Clk);
    Clr = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run_op(tbl[i], 1'b0);

    // Start during a run is ignored; first result stands.
    run_op(mk(FN_MULTU, 32'd100, 32'd200, 32'd0, 32'd20000, 1'b0), 1'b1);
    repeat (3) begin
      @(negedge Clk);
      chk("no_restart_busy", {63'd0, Busy}, 64'd0);
    end

    // Invalid funct in IDLE is ignored.
    @(negedge Clk);
    Start = 1'b1; Funct = 6'b100000; A = 32'd9; B = 32'd9;
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) begin
      chk("bad_funct_busy", {63'd0, Busy}, 64'd0);
      chk("bad_funct_done", {63'd0, Done}, 64'd0);
      @(negedge Clk);
    end

    // Leave DivZero set and Hi/Lo non-zero, then abort a DIV with Clr.
    run_op(mk(FN_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1), 1'b0);
    @(negedge Clk);
    Start = 1'b1; Funct = FN_DIV; A = 32'd100; B = 32'd3;
    @(negedge Clk);
    Start = 1'b0;
    repeat (10) @(negedge Clk);
    chk("pre_clr_busy", {63'd0, Busy}, 64'd1);
    Clr = 1'b1;
    #1;
    chk("clr_busy", {63'd0, Busy}, 64'd0);
    chk("clr_done", {63'd0, Done}, 64'd0);
    chk("clr_hilo", {Hi, Lo}, 64'd0);
    chk("clr_dz", {63'd0, DivZero}, 64'd0);
    @(negedge Clk);
    Clr = 1'b0;
    prev_hi = '0;
    prev_lo = '0;
    run_op(mk(FN_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0), 1'b0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
